// File: rtl/alu_status_reg.sv
// CTI-8 status/flag register: captures ALU flags, feeds C/H back to the ALU, supports SR load,
// single-flag ops and (when CTI8_FLAG_STACK_EN is defined) a LIFO save/restore stack.
module alu_status_reg #(
    parameter int STACK_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] alu_result,
    input  logic       alu_c,
    input  logic       alu_v,
    input  logic       alu_h,
    input  logic       flag_update,
    input  logic [4:0] flag_mask,
    input  logic       sr_load,
    input  logic [7:0] sr_din,
    input  logic [2:0] flag_op,
    input  logic       push,
    input  logic       pop,
    output logic [7:0] status,
    output logic       carry_fb,
    output logic       half_fb,
    output logic       stack_empty,
    output logic       stack_full,
    output logic       stack_err
);
    localparam int C_BIT = 0;
    localparam int Z_BIT = 1;
    localparam int N_BIT = 2;
    localparam int V_BIT = 3;
    localparam int H_BIT = 4;
    localparam int I_BIT = 5;

    localparam logic [2:0] OP_CLC = 3'd1;
    localparam logic [2:0] OP_SEC = 3'd2;
    localparam logic [2:0] OP_CLI = 3'd3;
    localparam logic [2:0] OP_SEI = 3'd4;
    localparam logic [2:0] OP_CLV = 3'd5;

    // Only the six architectural flags are stored; bits [7:6] of status read as zero.
    logic [5:0] flags_q;
    logic [5:0] flags_d;
    logic       pop_load;
    logic [5:0] pop_value;
    logic       unused_inputs;

    always_comb begin
        flags_d = flags_q;
        if (pop_load) begin
            flags_d = pop_value;
        end else if (sr_load) begin
            flags_d = sr_din[5:0];
        end else if (flag_update) begin
            if (flag_mask[0]) flags_d[C_BIT] = alu_c;
            if (flag_mask[1]) flags_d[Z_BIT] = (alu_result == 8'h00);
            if (flag_mask[2]) flags_d[N_BIT] = alu_result[7];
            if (flag_mask[3]) flags_d[V_BIT] = alu_v;
            if (flag_mask[4]) flags_d[H_BIT] = alu_h;
        end else begin
            case (flag_op)
                OP_CLC:  flags_d[C_BIT] = 1'b0;
                OP_SEC:  flags_d[C_BIT] = 1'b1;
                OP_CLI:  flags_d[I_BIT] = 1'b0;
                OP_SEI:  flags_d[I_BIT] = 1'b1;
                OP_CLV:  flags_d[V_BIT] = 1'b0;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q <= 6'h00;
        end else begin
            flags_q <= flags_d;
        end
    end

    assign status   = {2'b00, flags_q};
    assign carry_fb = flags_q[C_BIT];
    assign half_fb  = flags_q[H_BIT];

`ifdef CTI8_FLAG_STACK_EN
    localparam int PW = $clog2(STACK_DEPTH + 1);
    localparam int AW = $clog2(STACK_DEPTH);

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;
    logic [PW-1:0] ptr_m1;
    logic          err_q;
    logic          err_d;
    logic          push_ok;
    logic          empty;
    logic          full;
    logic [5:0]    stack_mem [STACK_DEPTH];

    assign empty   = (ptr_q == '0);
    assign full    = (ptr_q == PW'(STACK_DEPTH));
    assign ptr_m1  = ptr_q - PW'(1);

    // A simultaneous push and pop cancels both; the stack never wraps.
    assign push_ok   = push & ~pop & ~full;
    assign pop_load  = pop & ~push & ~empty;
    assign pop_value = stack_mem[ptr_m1[AW-1:0]];
    assign err_d     = (push & pop) | (push & full) | (pop & empty);

    always_comb begin
        ptr_d = ptr_q;
        if (push_ok) begin
            ptr_d = ptr_q + PW'(1);
        end else if (pop_load) begin
            ptr_d = ptr_m1;
        end
    end

    // The saved entry is the status at the start of the cycle, not the value being written.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            stack_mem[ptr_q[AW-1:0]] <= flags_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
            err_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
            err_q <= err_d;
        end
    end

    assign stack_empty   = empty;
    assign stack_full    = full;
    assign stack_err     = err_q;
    assign unused_inputs = ^sr_din[7:6];
`else
    assign pop_load      = 1'b0;
    assign pop_value     = 6'h00;
    assign stack_empty   = 1'b1;
    assign stack_full    = 1'b0;
    assign stack_err     = 1'b0;
    assign unused_inputs = ^{sr_din[7:6], push, pop, 1'(STACK_DEPTH)};
`endif

endmodule

// File: tb/tb_alu_status_reg.sv
// Randomized self-checking bench for alu_status_reg against a queue-based behavioural model.
// Follows CTI8_FLAG_STACK_EN so the model matches whichever build is compiled.
module tb_alu_status_reg;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] alu_result;
    logic       alu_c, alu_v, alu_h;
    logic       flag_update;
    logic [4:0] flag_mask;
    logic       sr_load;
    logic [7:0] sr_din;
    logic [2:0] flag_op;
    logic       push, pop;
    logic [7:0] status;
    logic       carry_fb, half_fb, stack_empty, stack_full, stack_err;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] m_status;
    logic [7:0] m_stack[$];
    logic       m_err;

    always #5 clk = ~clk;

    alu_status_reg #(.STACK_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_result(alu_result), .alu_c(alu_c), .alu_v(alu_v), .alu_h(alu_h),
        .flag_update(flag_update), .flag_mask(flag_mask),
        .sr_load(sr_load), .sr_din(sr_din), .flag_op(flag_op),
        .push(push), .pop(pop),
        .status(status), .carry_fb(carry_fb), .half_fb(half_fb),
        .stack_empty(stack_empty), .stack_full(stack_full), .stack_err(stack_err)
    );

    task automatic idle();
        alu_result = 8'h00; alu_c = 1'b0; alu_v = 1'b0; alu_h = 1'b0;
        flag_update = 1'b0; flag_mask = 5'h00;
        sr_load = 1'b0; sr_din = 8'h00; flag_op = 3'd0;
        push = 1'b0; pop = 1'b0;
    endtask

    task automatic model_reset();
        m_status = 8'h00;
        m_stack.delete();
        m_err = 1'b0;
    endtask

    // One clock of architectural behaviour: stack action first, then the status priority chain.
    task automatic model_step();
        logic [7:0] nxt;
        bit popped;
        nxt = m_status;
        popped = 0;
        m_err = 1'b0;
`ifdef CTI8_FLAG_STACK_EN
        if (push && pop) begin
            m_err = 1'b1;
        end else if (push) begin
            if (m_stack.size() == DEPTH) m_err = 1'b1;
            else m_stack.push_back(m_status);
        end else if (pop) begin
            if (m_stack.size() == 0) m_err = 1'b1;
            else begin
                nxt = m_stack.pop_back();
                popped = 1;
            end
        end
`endif
        if (!popped) begin
            if (sr_load) begin
                nxt = {2'b00, sr_din[5:0]};
            end else if (flag_update) begin
                if (flag_mask[0]) nxt[0] = alu_c;
                if (flag_mask[1]) nxt[1] = (alu_result == 8'h00);
                if (flag_mask[2]) nxt[2] = alu_result[7];
                if (flag_mask[3]) nxt[3] = alu_v;
                if (flag_mask[4]) nxt[4] = alu_h;
            end else begin
                case (flag_op)
                    3'd1: nxt[0] = 1'b0;
                    3'd2: nxt[0] = 1'b1;
                    3'd3: nxt[5] = 1'b0;
                    3'd4: nxt[5] = 1'b1;
                    3'd5: nxt[3] = 1'b0;
                    default: ;
                endcase
            end
        end
        m_status = nxt;
    endtask

    function automatic logic [12:0] exp_vec();
        logic e_empty, e_full;
`ifdef CTI8_FLAG_STACK_EN
        e_empty = (m_stack.size() == 0);
        e_full  = (m_stack.size() == DEPTH);
`else
        e_empty = 1'b1;
        e_full  = 1'b0;
`endif
        return {m_status, m_status[0], m_status[4], e_empty, e_full, m_err};
    endfunction

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        #2;
        n_vec++;
        if ({status, carry_fb, half_fb, stack_empty, stack_full, stack_err} !== {8'h00, 5'b00100}) begin
            $display("FAIL reset: status=%h fb=%b%b e/f/err=%b%b%b expected 00 00 100",
                     status, carry_fb, half_fb, stack_empty, stack_full, stack_err);
            n_err++;
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_flag_update();
        logic [12:0] exp;
        idle();
        flag_update = 1'b1; flag_mask = 5'h1F; alu_result = 8'h00;
        alu_c = 1'b1; alu_v = 1'b0; alu_h = 1'b1;
        tick();
        n_vec++;
        if ({status, carry_fb, half_fb} !== {8'h13, 1'b1, 1'b1}) begin
            $display("FAIL upd_all: status=%h cfb=%b hfb=%b expected 13 1 1", status, carry_fb, half_fb);
            n_err++;
        end
        flag_mask = 5'h06; alu_result = 8'h80; alu_v = 1'b1; alu_c = 1'b0; alu_h = 1'b0;
        tick();
        n_vec++;
        if ({status, carry_fb, half_fb} !== {8'h15, 1'b1, 1'b1}) begin
            $display("FAIL upd_mask: status=%h cfb=%b hfb=%b expected 15 1 1", status, carry_fb, half_fb);
            n_err++;
        end
        for (int i = 0; i < 24; i++) begin
            flag_mask  = 5'($urandom);
            alu_result = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            alu_c = 1'($urandom); alu_v = 1'($urandom); alu_h = 1'($urandom);
            tick();
            exp = exp_vec();
            n_vec++;
            if ({status, carry_fb, half_fb, stack_empty, stack_full, stack_err} !== exp) begin
                $display("FAIL upd_rand[%0d]: got %h expected %h", i,
                         {status, carry_fb, half_fb, stack_empty, stack_full, stack_err}, exp);
                n_err++;
            end
        end
        idle();
    endtask

    task automatic test_priority();
        logic [12:0] exp;
        idle();
        sr_load = 1'b1; sr_din = 8'hFF; flag_update = 1'b1; flag_mask = 5'h1F; flag_op = 3'd2;
        tick();
        n_vec++;
        if (status !== 8'h3F) begin
            $display("FAIL prio_load: status=%h expected 3F", status);
            n_err++;
        end
        idle();
        flag_op = 3'd1;
        tick();
        n_vec++;
        if (status !== 8'h3E) begin
            $display("FAIL prio_clc: status=%h expected 3E", status);
            n_err++;
        end
        for (int i = 0; i < 40; i++) begin
            sr_load     = ($urandom_range(0, 3) == 0);
            sr_din      = 8'($urandom);
            flag_update = ($urandom_range(0, 2) == 0);
            flag_mask   = 5'($urandom);
            flag_op     = 3'($urandom);
            alu_result  = 8'($urandom);
            alu_c = 1'($urandom); alu_v = 1'($urandom); alu_h = 1'($urandom);
            tick();
            exp = exp_vec();
            n_vec++;
            if ({status, carry_fb, half_fb, stack_empty, stack_full, stack_err} !== exp) begin
                $display("FAIL prio_rand[%0d]: got %h expected %h", i,
                         {status, carry_fb, half_fb, stack_empty, stack_full, stack_err}, exp);
                n_err++;
            end
        end
        idle();
    endtask

`ifdef CTI8_FLAG_STACK_EN
    task automatic test_stack();
        logic [7:0] pops [4];
        pops[0] = 8'h08; pops[1] = 8'h04; pops[2] = 8'h02; pops[3] = 8'h01;
        idle();
        sr_load = 1'b1; sr_din = 8'h01;
        tick();
        // Each push saves the pre-update status while sr_load installs the next value.
        push = 1'b1; sr_din = 8'h02; tick();
        sr_din = 8'h04; tick();
        sr_din = 8'h08; tick();
        sr_load = 1'b0; tick();
        n_vec++;
        if ({status, stack_full, stack_empty} !== {8'h08, 2'b10}) begin
            $display("FAIL stk_full: status=%h full=%b empty=%b expected 08 1 0", status, stack_full, stack_empty);
            n_err++;
        end
        tick();
        n_vec++;
        if ({status, stack_full, stack_err} !== {8'h08, 2'b11}) begin
            $display("FAIL stk_ovf: status=%h full=%b err=%b expected 08 1 1", status, stack_full, stack_err);
            n_err++;
        end
        idle();
        tick();
        n_vec++;
        if (stack_err !== 1'b0) begin
            $display("FAIL stk_err_pulse: err=%b expected 0", stack_err);
            n_err++;
        end
        pop = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_vec++;
            if ({status, stack_err} !== {pops[i], 1'b0}) begin
                $display("FAIL stk_pop[%0d]: status=%h err=%b expected %h 0", i, status, stack_err, pops[i]);
                n_err++;
            end
        end
        n_vec++;
        if (stack_empty !== 1'b1) begin
            $display("FAIL stk_empty: empty=%b expected 1", stack_empty);
            n_err++;
        end
        tick();
        n_vec++;
        if ({status, stack_err, stack_empty} !== {8'h01, 2'b11}) begin
            $display("FAIL stk_udf: status=%h err=%b empty=%b expected 01 1 1", status, stack_err, stack_empty);
            n_err++;
        end
        idle();
        tick();
    endtask
`else
    task automatic test_stack();
        idle();
        sr_load = 1'b1; sr_din = 8'h2A;
        tick();
        idle();
        push = 1'b1; tick();
        push = 1'b0; pop = 1'b1; tick();
        push = 1'b1; tick();
        n_vec++;
        if ({status, stack_empty, stack_full, stack_err} !== {8'h2A, 3'b100}) begin
            $display("FAIL stk_off: status=%h e/f/err=%b%b%b expected 2A 100",
                     status, stack_empty, stack_full, stack_err);
            n_err++;
        end
        idle();
    endtask
`endif

    task automatic test_collision();
        logic [12:0] exp;
        idle();
        sr_load = 1'b1; sr_din = 8'h05;
        tick();
        idle();
        push = 1'b1; tick();
        pop = 1'b1; flag_op = 3'd4;
        tick();
        exp = exp_vec();
        n_vec++;
        if ({status, carry_fb, half_fb, stack_empty, stack_full, stack_err} !== exp) begin
            $display("FAIL collide: got %h expected %h",
                     {status, carry_fb, half_fb, stack_empty, stack_full, stack_err}, exp);
            n_err++;
        end
        n_vec++;
        if (status[5] !== 1'b1) begin
            $display("FAIL collide_sei: I=%b expected 1", status[5]);
            n_err++;
        end
        idle();
        pop = 1'b1;
        tick();
        exp = exp_vec();
        n_vec++;
        if ({status, carry_fb, half_fb, stack_empty, stack_full, stack_err} !== exp) begin
            $display("FAIL collide_pop: got %h expected %h",
                     {status, carry_fb, half_fb, stack_empty, stack_full, stack_err}, exp);
            n_err++;
        end
        idle();
    endtask

    task automatic test_async_reset();
        idle();
        sr_load = 1'b1; sr_din = 8'h03; tick();
        sr_load = 1'b0; push = 1'b1; tick();
        tick();
        // Reset lands mid-cycle while a third push is pending.
        #3;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({status, stack_empty, stack_err} !== {8'h00, 2'b10}) begin
            $display("FAIL async_rst: status=%h empty=%b err=%b expected 00 1 0", status, stack_empty, stack_err);
            n_err++;
        end
        idle();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_back_to_back();
        logic [12:0] exp;
        for (int i = 0; i < 300; i++) begin
            sr_load     = ($urandom_range(0, 5) == 0);
            sr_din      = 8'($urandom);
            flag_update = ($urandom_range(0, 2) == 0);
            flag_mask   = 5'($urandom);
            flag_op     = 3'($urandom);
            alu_result  = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
            alu_c = 1'($urandom); alu_v = 1'($urandom); alu_h = 1'($urandom);
            push = ($urandom_range(0, 2) == 0);
            pop  = ($urandom_range(0, 2) == 0);
            tick();
            exp = exp_vec();
            n_vec++;
            if ({status, carry_fb, half_fb, stack_empty, stack_full, stack_err} !== exp) begin
                $display("FAIL b2b[%0d]: got %h expected %h", i,
                         {status, carry_fb, half_fb, stack_empty, stack_full, stack_err}, exp);
                n_err++;
            end
        end
        idle();
    endtask

    initial begin
        model_reset();
        test_reset();
        test_flag_update();
        test_priority();
        test_stack();
        test_collision();
        test_async_reset();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/alu_status_reg.md
Name: alu_status_reg

Overview:
- Status/flag register directly downstream of the CTI-8 ALU.
- Captures the ALU's C/V/H outputs and derives Z/N from its 8-bit result under a per-flag write mask.
- Feeds the current C and H back to the ALU's carryIn/halfCarry inputs for ADD/SUB/ROL/ROR/DAA chains.
- Provides direct SR load, single-flag set/clear ops, and a small flag save/restore stack for interrupt entry/return.

Parameters:
STACK_DEPTH, 4, number of 8-bit status entries in the save stack (2..8)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  reset, asynchronous, active-low
alu_result  input  8  ALU result bus (Z/N source)
alu_c  input  1  ALU carry out
alu_v  input  1  ALU overflow out
alu_h  input  1  ALU half-carry out
flag_update  input  1  capture ALU flags this cycle
flag_mask  input  5  per-flag write enable for flag_update: [0]C [1]Z [2]N [3]V [4]H
sr_load  input  1  load status from sr_din
sr_din  input  8  status value for sr_load
flag_op  input  3  0 none, 1 CLC, 2 SEC, 3 CLI, 4 SEI, 5 CLV, 6/7 none
push  input  1  save current status to stack
pop  input  1  restore status from stack
status  output  8  {2'b00, I, H, V, N, Z, C}
carry_fb  output  1  status[0], drives ALU carryIn
half_fb  output  1  status[4], drives ALU halfCarry
stack_empty  output  1  stack holds no entries
stack_full  output  1  stack holds STACK_DEPTH entries
stack_err  output  1  one-cycle pulse on overflow, underflow, or push+pop collision

Behaviour:
- Reset (async assert, sync release on clk): status=8'h00, stack pointer=0, stack_empty=1, stack_full=0, stack_err=0. Reset mid-push/pop discards the operation; stack contents are don't-care.
- Outputs are registered; status/carry_fb/half_fb reflect updates one cycle after the strobe.
- Z = (alu_result==8'h00); N = alu_result[7]. Flags whose mask bit is 0 keep their value. I is never touched by flag_update.
- Per-cycle write priority for the status register, highest first: pop (valid) > sr_load > flag_update > flag_op.
- Lower-priority sources are dropped entirely in that cycle; there is no bitwise merge.
- sr_load writes sr_din[5:0]. Bits [7:6] are forced to 0.
- flag_op modifies only the named bit.
- Stack is LIFO with a pointer 0..STACK_DEPTH.
- push with !full: writes the pre-update status (the value at the start of the cycle) at ptr; ptr+1. Same-cycle status updates still apply to the register.
- push with full: no write, ptr unchanged, stack_err=1 for one cycle.
- pop with !empty: ptr-1; status <= entry[ptr-1].
- pop with empty: status follows the remaining priority chain, stack_err=1.
- push and pop in the same cycle: stack and ptr unchanged, pop does not load status, other sources apply, stack_err=1.
- stack_empty = (ptr==0); stack_full = (ptr==STACK_DEPTH); both combinational from the registered ptr.
- The stack never wraps.

Optional Feature:
- Macro: CTI8_FLAG_STACK_EN.
- Defined: save stack present as described above.
- Undefined: no stack storage. push/pop are ignored; stack_empty=1, stack_full=0, stack_err=0 constantly. Status priority reduces to sr_load > flag_update > flag_op.

Test Plan:
- Reset then flag_update, mask=5'h1F, alu_result=8'h00, alu_c=1, alu_v=0, alu_h=1 -> next cycle status=8'h13, carry_fb=1, half_fb=1.
- status=8'h13, flag_update with mask=5'h06, alu_result=8'h80, alu_v=1 -> status=8'h15 (Z=0, N=1, C/H kept, V unchanged at 0).
- sr_load=1 with sr_din=8'hFF, flag_update=1 and flag_op=SEC in the same cycle -> status=8'h3F (sr_load wins, [7:6] forced 0); then flag_op=CLC -> 8'h3E.
- STACK_DEPTH=4: push status values 01,02,04,08 -> stack_full=1. Fifth push -> stack_err pulse, ptr unchanged. Four pops -> status 08,04,02,01 in order, then stack_empty=1. Fifth pop -> stack_err pulse, status unchanged.
- push and pop together with the stack holding 1 entry plus flag_op=SEI -> stack_err=1, ptr unchanged, status I bit set.
- Assert rst_n=0 mid-cycle during a push to a 2-entry stack -> status=8'h00 and stack_empty=1 immediately, without waiting for a clock edge.
